cnn16_prog_loader: RTL

CNN16_PROG_LOADER -- requirements
Module: cnn16_prog_loader

---
 rtl/cnn16_prog_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cnn16_prog_loader.sv
// Program loader for the CNN_16 word RAM: pairs incoming bytes into 16-bit words and writes them at base+count.
// Optional trailing-checksum verification is built in when CNN16_LOADER_CHECKSUM_EN is defined.
module cnn16_prog_loader #(
  parameter int HI_FIRST = 1
) (
  input  logic        clkn,
  input  logic        rstn,
  input  logic        start,
  input  logic [11:0] base_adr,
  input  logic [11:0] len,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        sel_out,
  output logic        we_out,
  output logic [11:0] adr_out,
  output logic [15:0] data_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BYTE0 = 3'd1,
    BYTE1 = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
`ifdef CNN16_LOADER_CHECKSUM_EN
    ,
    CHK0  = 3'd5,
    CHK1  = 3'd6
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] base_q, len_q, cnt_q, adr_q;
  logic [7:0]  byte_q;
  logic [15:0] data_q;
  logic [15:0] word_w;
  logic [11:0] cntInc_w;

  // The held byte and the byte on the bus form the word; order depends on HI_FIRST.
  assign word_w   = (HI_FIRST != 0) ? {byte_q, rx_data} : {rx_data, byte_q};
  assign cntInc_w = cnt_q + 12'd1;

  always_ff @(posedge clkn or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (len == 12'd0) ? FIN : BYTE0;
      BYTE0: if (rx_valid) state_d = BYTE1;
      BYTE1: if (rx_valid) state_d = WRITE;
`ifdef CNN16_LOADER_CHECKSUM_EN
      WRITE: state_d = (cntInc_w == len_q) ? CHK0 : BYTE0;
      CHK0:  if (rx_valid) state_d = CHK1;
      CHK1:  if (rx_valid) state_d = FIN;
`else
      WRITE: state_d = (cntInc_w == len_q) ? FIN : BYTE0;
`endif
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    we_out   = 1'b0;
    done     = 1'b0;
    sel_out  = (state_q != IDLE);
    case (state_q)
      BYTE0, BYTE1: rx_ready = 1'b1;
`ifdef CNN16_LOADER_CHECKSUM_EN
      CHK0, CHK1:   rx_ready = 1'b1;
`endif
      WRITE:        we_out   = 1'b1;
      FIN:          done     = 1'b1;
      default:      ;
    endcase
  end

  assign busy     = sel_out;
  assign adr_out  = adr_q;
  assign data_out = data_q;

  // Address and word are registered as the second byte lands, so they are valid for the whole WRITE cycle and hold after it.
  always_ff @(posedge clkn or negedge rstn) begin
    if (!rstn) begin
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      byte_q <= '0;
      adr_q  <= '0;
      data_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          base_q <= base_adr;
          len_q  <= len;
          cnt_q  <= '0;
        end
        BYTE0: if (rx_valid) byte_q <= rx_data;
        BYTE1: if (rx_valid) begin
          adr_q  <= base_q + cnt_q;
          data_q <= word_w;
        end
        WRITE: cnt_q <= cntInc_w;
`ifdef CNN16_LOADER_CHECKSUM_EN
        CHK0: if (rx_valid) byte_q <= rx_data;
`endif
        default: ;
      endcase
    end
  end

`ifdef CNN16_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;
  logic        err_q;

  // Running sum of written words; the error flag stays set until the next start.
  always_ff @(posedge clkn or negedge rstn) begin
    if (!rstn) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:  if (start) begin
          sum_q <= '0;
          err_q <= 1'b0;
        end
        WRITE: sum_q <= sum_q + data_q;
        CHK1:  if (rx_valid) err_q <= (word_w != sum_q);
        default: ;
      endcase
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
